// File: rtl/branch_predictor_btb.sv
// Bimodal/gshare branch predictor with a direct-mapped BTB. Lookup is combinational.
// Training writes at the clock edge. Saturating branch and mispredict counters are included.
module branch_predictor_btb #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6,
   parameter int CTR_WIDTH  = 2,
   parameter int GHR_BITS   = 4,
   parameter int PERF_WIDTH = 32,
   localparam int GW        = (GHR_BITS > 0) ? GHR_BITS : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lookup_valid,
   input  logic [DATA_WIDTH-1:0] lookup_pc,
   output logic                  predict_hit,
   output logic                  predict_taken,
   output logic [DATA_WIDTH-1:0] predict_target,
   output logic [GW-1:0]         lookup_ghr,
   input  logic                  update_valid,
   input  logic [DATA_WIDTH-1:0] update_pc,
   input  logic                  update_taken,
   input  logic [DATA_WIDTH-1:0] update_target,
   input  logic [GW-1:0]         update_ghr,
   input  logic                  update_mispredict,
   output logic [PERF_WIDTH-1:0] branch_count,
   output logic [PERF_WIDTH-1:0] mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TW      = DATA_WIDTH - INDEX_BITS - 2;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
   localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

   logic                  tbl_valid  [ENTRIES];
   logic [TW-1:0]         tbl_tag    [ENTRIES];
   logic [DATA_WIDTH-1:0] tbl_target [ENTRIES];
   logic [CTR_WIDTH-1:0]  tbl_ctr    [ENTRIES];

   logic [GW-1:0]         ghr;
   logic [INDEX_BITS-1:0] lk_idx;
   logic [INDEX_BITS-1:0] up_idx;
   logic [TW-1:0]         lk_tag;
   logic [TW-1:0]         up_tag;
   logic                  up_hit;
   logic                  unused_pc_bits;

   // History is zero-extended into the low index bits; with no history it XORs with zero.
   function automatic logic [INDEX_BITS-1:0] hash_index(input logic [DATA_WIDTH-1:0] pc,
                                                         input logic [GW-1:0] g);
      logic [INDEX_BITS-1:0] ext;
      ext = '0;
      if (GHR_BITS > 0) ext[GW-1:0] = g;
      return pc[INDEX_BITS+1:2] ^ ext;
   endfunction

   assign lk_idx = hash_index(lookup_pc, ghr);
   assign up_idx = hash_index(update_pc, update_ghr);
   assign lk_tag = lookup_pc[DATA_WIDTH-1:INDEX_BITS+2];
   assign up_tag = update_pc[DATA_WIDTH-1:INDEX_BITS+2];
   assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   assign predict_hit    = lookup_valid && !reset && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
   assign predict_taken  = predict_hit && tbl_ctr[lk_idx][CTR_WIDTH-1];
   assign predict_target = predict_hit ? tbl_target[lk_idx] : '0;
   assign lookup_ghr     = ghr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i] <= 1'b0;
            tbl_ctr[i]   <= CTR_WNT;
         end
      end else if (update_valid) begin
         if (up_hit) begin
            if (update_taken) begin
               if (tbl_ctr[up_idx] != CTR_MAX) tbl_ctr[up_idx] <= tbl_ctr[up_idx] + 1'b1;
            end else if (tbl_ctr[up_idx] != '0) begin
               tbl_ctr[up_idx] <= tbl_ctr[up_idx] - 1'b1;
            end
         end else if (update_taken) begin
            tbl_valid[up_idx] <= 1'b1;
            tbl_ctr[up_idx]   <= CTR_WT;
         end
      end
   end

   // Tag/target need no reset: valid gates them, and updates during reset are dropped.
   always_ff @(posedge clk) begin
      if (update_valid && !reset && update_taken) begin
         tbl_target[up_idx] <= update_target;
         if (!up_hit) tbl_tag[up_idx] <= up_tag;
      end
   end

   generate
      if (GHR_BITS == 0) begin : g_no_ghr
         assign ghr = '0;
      end else begin : g_ghr
         logic [GW-1:0] rec_val;
         logic [GW-1:0] spec_val;
         if (GHR_BITS == 1) begin : g_one
            assign rec_val  = update_taken;
            assign spec_val = predict_taken;
         end else begin : g_multi
            assign rec_val  = {update_ghr[GW-2:0], update_taken};
            assign spec_val = {ghr[GW-2:0], predict_taken};
         end
         // Mispredict recovery overrides the speculative shift from this cycle's lookup.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ghr <= '0;
            end else if (update_valid && update_mispredict) begin
               ghr <= rec_val;
            end else if (predict_hit) begin
               ghr <= spec_val;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (update_valid) begin
         if (branch_count != '1) branch_count <= branch_count + 1'b1;
         if (update_mispredict && (mispredict_count != '1))
            mispredict_count <= mispredict_count + 1'b1;
      end
   end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised dynamic branch predictor with branch target buffer (BTB). It sits beside the fetch stage of the pipelined ARM core: PCF is looked up combinationally each cycle to produce a taken/target prediction. Resolved branches from Execute train the table. It generalises a fixed bimodal predictor with:
- configurable table depth and counter width
- optional gshare global-history indexing with mispredict recovery
- saturating performance counters

Parameters:
DATA_WIDTH, 32, PC/target width
INDEX_BITS, 6, table has 2^INDEX_BITS entries; index base = pc[INDEX_BITS+1:2]
CTR_WIDTH, 2, saturating counter width (legal 1..4)
GHR_BITS, 4, global history length; 0 = pure bimodal; legal 0..INDEX_BITS
PERF_WIDTH, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lookup_valid  in  1  fetch is presenting a PC this cycle
lookup_pc  in  DATA_WIDTH  PCF
predict_hit  out  1  valid entry with tag match at lookup index
predict_taken  out  1  predict_hit AND counter MSB
predict_target  out  DATA_WIDTH  stored target; 0 when not hit
lookup_ghr  out  max(GHR_BITS,1)  GHR used for this lookup; carried down the pipe
update_valid  in  1  branch resolved in Execute
update_pc  in  DATA_WIDTH  PC of resolved branch
update_taken  in  1  actual outcome
update_target  in  DATA_WIDTH  actual target
update_ghr  in  max(GHR_BITS,1)  lookup_ghr snapshot carried with this branch
update_mispredict  in  1  outcome or target differed from prediction
branch_count  out  PERF_WIDTH  resolved branches
mispredict_count  out  PERF_WIDTH  mispredicted branches

Behaviour:
- Entry fields: valid, tag = pc[DATA_WIDTH-1:INDEX_BITS+2], target, counter.
- Lookup index = pc[INDEX_BITS+1:2] XOR zero-extended GHR. Update index uses update_ghr in place of the GHR. With GHR_BITS=0 there is no XOR and lookup_ghr = 0.
- Lookup latency: zero cycles (combinational). Outputs are gated by lookup_valid; when it is low, hit/taken/target are all 0.
- Update takes effect at the clock edge. A lookup in the same cycle sees pre-update contents (no bypass).
- Update on tag hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_WIDTH-1. Target is overwritten only when taken.
- Update on miss/invalid:
  - taken: allocate, overwriting any aliased entry. Set valid=1, tag, target, counter = 2^(CTR_WIDTH-1) (weakly taken).
  - not taken: no allocation.
- GHR (GHR_BITS>0), evaluated each edge in priority order:
  1. update_valid & update_mispredict: GHR <= {update_ghr[GHR_BITS-2:0], update_taken}
  2. else lookup_valid & predict_hit: GHR <= {GHR[GHR_BITS-2:0], predict_taken}
  3. else hold
  For GHR_BITS=1 the shift degenerates to GHR <= the new bit.
- Perf counters: branch_count +1 per update_valid; mispredict_count +1 when update_valid & update_mispredict. Both saturate at all-ones and never wrap. update_mispredict is ignored when update_valid=0.
- Reset (asynchronous, any cycle including mid-update):
  - all valid=0
  - counters = 2^(CTR_WIDTH-1)-1 (weakly not-taken)
  - GHR=0, perf counters=0
  - predict_* fall to 0 immediately, without waiting for a clock edge
  - any update present while reset is asserted is discarded

Test Plan:
- Cold miss (INDEX_BITS=6, GHR_BITS=0): after reset, lookup 0x0000_0040 -> predict_hit=0, predict_taken=0, predict_target=0.
- Allocation and training: update pc=0x40, taken=1, target=0x100 -> next-cycle lookup 0x40 gives hit=1, taken=1, target=0x100. Two not-taken updates -> taken=0, hit=1. Ten taken updates -> counter saturates at 3; one not-taken update -> still taken.
- Aliasing: entry for 0x40 present; taken update pc=0x1040, target=0x200 -> lookup 0x40 gives hit=0; lookup 0x1040 gives target 0x200. Not-taken update to a fresh PC 0x80 -> no allocation; lookup 0x80 gives hit=0.
- Same-cycle lookup/update of 0x40 (counter 1 -> 2) -> that cycle taken=0; next cycle taken=1.
- Gshare recovery (GHR_BITS=4): three hit-taken lookups -> GHR=4'b0111. Mispredict update with update_ghr=4'b0001, taken=0 in the same cycle as a hit lookup -> GHR=4'b0010 (recovery wins). mispredict_count=1.
- Reset mid-run and perf saturation: assert reset asynchronously between edges -> predict_hit drops to 0 before the next edge and counters clear. With PERF_WIDTH=4, 20 updates -> branch_count=15.
